// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP,
    FILL
  } fetch_state_t;

  localparam int          BYTES_PER_INST = 4;
  localparam logic [31:0] DEFAULT_NOP    = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_timer.sv
// Per-byte handshake watchdog: counts REQ cycles without ack, saturating.
module fetch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int           W    = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] TOP  = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (run && count != TOP)
      count <= count + 1'b1;
  end

  // The current cycle is the TIMEOUT-th un-acked one, so the request ends here.
  assign expired = run && (count >= LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: assembles 32-bit words from a byte-wide memory behind a one-entry tag.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              stall,
  output logic              fault,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  fetch_state_t      state, state_next;
  logic [31:0]       base, tag, fill_buf;
  logic [1:0]        cnt;
  logic              tag_valid;
  logic [ADDR_W-1:0] addr_q, cur_addr;
  logic              hit, misaligned, last_byte;
  logic              timer_clear, timer_run, expired;

  assign hit        = tag_valid && (tag == pc);
  assign misaligned = pc[1:0] != 2'b00;
  assign last_byte  = cnt == 2'(BYTES_PER_INST - 1);
  assign cur_addr   = base[ADDR_W-1:0] + ADDR_W'(cnt);
  assign inst_valid = hit;
  assign stall      = !hit;

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .run    (timer_run),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!hit && !misaligned) state_next = REQ;
      REQ: begin
        if (mem_ack)
          state_next = last_byte ? FILL : GAP;
        else if (expired)
          state_next = IDLE;
      end
      GAP:     state_next = REQ;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req     = state == REQ;
    mem_addr    = (state == REQ) ? cur_addr : addr_q;
    timer_clear = state != REQ;
    timer_run   = (state == REQ) && !mem_ack;
  end

  // A started fetch always runs to FILL or timeout, even if pc moves meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= '0;
      cnt       <= '0;
      fill_buf  <= '0;
      tag       <= '0;
      tag_valid <= 1'b0;
      inst      <= NOP_INST;
      fault     <= 1'b0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit && misaligned) begin
            fault     <= 1'b1;
            tag       <= pc;
            tag_valid <= 1'b1;
            inst      <= NOP_INST;
          end else if (!hit) begin
            base <= pc;
            cnt  <= '0;
          end
        end
        REQ: begin
          addr_q <= cur_addr;
          if (mem_ack) begin
            fill_buf[{cnt, 3'b000} +: 8] <= mem_rdata;
            if (!last_byte)
              cnt <= cnt + 2'd1;
          end else if (expired) begin
            fault     <= 1'b1;
            tag       <= base;
            tag_valid <= 1'b1;
            inst      <= NOP_INST;
          end
        end
        FILL: begin
          inst      <= fill_buf;
          tag       <= base;
          tag_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
